// File: rtl/mem_access_if.sv
// Data-bus interface between the memory-access stage (master) and the data memory (slave).
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory-access stage: passes ALU results through to MEM/WB and runs one
// big-endian load/store bus transfer at a time, stalling the pipeline until ack.
// Optional feature macro MEM_MISALIGN_EXC_EN: misaligned halfword/word accesses raise
// exc_misalign instead of being silently aligned down.
module mem_access (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          mem_wd,
    input  logic                mem_wreg,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_op,
    input  logic [31:0]         mem_sdata,
    mem_access_if.master        bus,
    output logic                stallreq,
    output logic [4:0]          wb_wd,
    output logic                wb_wreg,
    output logic [31:0]         wb_wdata,
    output logic                exc_misalign
);
    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic        breq_q, breq_d;
    logic        bwe_q, bwe_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  bsel_q, bsel_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        exc_q, exc_d;
    logic        stall_raw;

    logic        is_load, is_store, is_half, is_word, misalign;
    logic [31:0] eff_addr;
    logic [3:0]  sel_new;
    logic [31:0] sdata_new;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    // Decode the incoming operation, its effective address, byte lanes and store data.
    always_comb begin
        is_load  = (mem_op >= OpLb) && (mem_op <= OpLw);
        is_store = (mem_op >= OpSb) && (mem_op <= OpSw);
        is_half  = (mem_op == OpLh) || (mem_op == OpLhu) || (mem_op == OpSh);
        is_word  = (mem_op == OpLw) || (mem_op == OpSw);
        eff_addr = mem_wdata;
`ifdef MEM_MISALIGN_EXC_EN
        misalign = (is_half && mem_wdata[0]) || (is_word && (mem_wdata[1:0] != 2'b00));
`else
        misalign = 1'b0;
        // Without the exception, misaligned accesses are silently aligned down.
        if (is_half) eff_addr[0] = 1'b0;
        if (is_word) eff_addr[1:0] = 2'b00;
`endif
        if (is_half) begin
            sel_new = eff_addr[1] ? 4'b0011 : 4'b1100;
        end else if (is_word) begin
            sel_new = 4'b1111;
        end else begin
            sel_new = 4'b1000 >> eff_addr[1:0];
        end
        unique case (mem_op)
            OpSb:    sdata_new = {4{mem_sdata[7:0]}};
            OpSh:    sdata_new = {2{mem_sdata[15:0]}};
            default: sdata_new = mem_sdata;
        endcase
    end

    // Extract and extend the addressed big-endian lane of the returned read data.
    always_comb begin
        byte_v = 8'(bus.bus_rdata >> {~off_q, 3'b000});
        half_v = off_q[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
        unique case (op_q)
            OpLb:    load_data = {{24{byte_v[7]}}, byte_v};
            OpLbu:   load_data = {24'b0, byte_v};
            OpLh:    load_data = {{16{half_v[15]}}, half_v};
            OpLhu:   load_data = {16'b0, half_v};
            default: load_data = bus.bus_rdata;
        endcase
    end

    // Next-state and stall logic: issue in IDLE, wait for ack in BUSY.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        breq_d     = breq_q;
        bwe_d      = bwe_q;
        baddr_d    = baddr_q;
        bsel_d     = bsel_q;
        bwdata_d   = bwdata_q;
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        exc_d      = 1'b0;
        stall_raw  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!is_load && !is_store) begin
                    wb_wd_d    = mem_wd;
                    wb_wreg_d  = mem_wreg;
                    wb_wdata_d = mem_wdata;
                end else if (misalign) begin
                    wb_wreg_d = 1'b0;
                    exc_d     = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    op_d      = mem_op;
                    off_d     = eff_addr[1:0];
                    wd_d      = mem_wd;
                    wreg_d    = mem_wreg;
                    breq_d    = 1'b1;
                    bwe_d     = is_store;
                    baddr_d   = {eff_addr[31:2], 2'b00};
                    bsel_d    = sel_new;
                    bwdata_d  = sdata_new;
                    wb_wreg_d = 1'b0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (bus.bus_ack) begin
                    breq_d    = 1'b0;
                    wb_wd_d   = wd_q;
                    // Stores never write back; loads are ops below OpSb.
                    wb_wreg_d = wreg_q && (op_q < OpSb);
                    if (op_q < OpSb) wb_wdata_d = load_data;
                    state_d   = StIdle;
                end else begin
                    stall_raw = 1'b1;
                    wb_wreg_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_q       <= 4'd0;
            off_q      <= 2'd0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            breq_q     <= 1'b0;
            bwe_q      <= 1'b0;
            baddr_q    <= 32'd0;
            bsel_q     <= 4'd0;
            bwdata_q   <= 32'd0;
            wb_wd_q    <= 5'd0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= 32'd0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            breq_q     <= breq_d;
            bwe_q      <= bwe_d;
            baddr_q    <= baddr_d;
            bsel_q     <= bsel_d;
            bwdata_q   <= bwdata_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            exc_q      <= exc_d;
        end
    end

    assign stallreq      = rst && stall_raw;
    assign bus.bus_req   = breq_q;
    assign bus.bus_we    = bwe_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_sel   = bsel_q;
    assign bus.bus_wdata = bwdata_q;
    assign wb_wd         = wb_wd_q;
    assign wb_wreg       = wb_wreg_q;
    assign wb_wdata      = wb_wdata_q;
    assign exc_misalign  = exc_q;
endmodule
